// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ACK.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       send,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = ($clog2(INHIBIT_CYCLES + 1) < 2) ? 2 : $clog2(INHIBIT_CYCLES + 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, RECOVER} state_t;
  state_t state_q, state_d;

  logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic          fall, lines_hi, timeout;
  logic [7:0]    tx_q, tx_d;
  logic          par_q, par_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          doe_q, doe_d;

  // Idle bus is high, so the synchronizers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall     = clk_prev_q & ~clk_s2_q;
  assign lines_hi = clk_s2_q & dat_s2_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          wd_act;

  // Counts cycles since START or the last device clock fall.
  assign wd_act  = (state_q == START) || (state_q == SEND) || (state_q == ACK);
  assign timeout = wd_act && !fall && (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign wd_d    = (wd_act && !fall) ? wd_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (send) state_d = INHIBIT;
      INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = START;
      START:   state_d = SEND;
      SEND:    if (fall && bit_q == 4'd9) state_d = ACK;
      ACK:     if (fall) state_d = RECOVER;
      RECOVER: if (lines_hi && cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = RECOVER;
  end

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    err         = timeout;
    case (state_q)
      INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (cnt_q == CW'(INHIBIT_CYCLES - 1));
      end
      START:   ps2_data_oe = 1'b1;
      SEND:    ps2_data_oe = doe_q;
      ACK: if (fall) begin
        done = ~dat_s2_q;
        err  = dat_s2_q;
      end
      default: ;
    endcase
  end

  // Datapath: byte/parity latch, bit counter, inhibit/recover counter, data drive.
  always_comb begin
    tx_d  = tx_q;
    par_d = par_q;
    bit_d = bit_q;
    cnt_d = '0;
    doe_d = doe_q;
    case (state_q)
      IDLE: if (send) begin
        tx_d  = wdata;
        par_d = ~^wdata;
      end
      INHIBIT: cnt_d = cnt_q + 1'b1;
      START: begin
        bit_d = 4'd0;
        doe_d = 1'b1;
      end
      SEND: if (fall) begin
        bit_d = bit_q + 1'b1;
        if (bit_q < 4'd8)       doe_d = ~tx_q[bit_q[2:0]];
        else if (bit_q == 4'd8) doe_d = ~par_q;
        else                    doe_d = 1'b0;
      end
      RECOVER: cnt_d = lines_hi ? cnt_q + 1'b1 : '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tx_q  <= '0;
      par_q <= 1'b0;
      bit_q <= '0;
      cnt_q <= '0;
      doe_q <= 1'b0;
    end else begin
      tx_q  <= tx_d;
      par_q <= par_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      doe_q <= doe_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector line model and a scaled-down device clock.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 300;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       send = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       clk_line, data_line;

  int errors = 0;
  int checks = 0;
  int done_n = 0;
  int err_n = 0;
  int both_n = 0;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  always #10 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clr(clr), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .send(send), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_n++;
    if (err === 1'b1) err_n++;
    if (done === 1'b1 && err === 1'b1) both_n++;
  end

  task automatic do_send(input logic [7:0] d, output int ccyc, output int dcyc,
                         output bit dlast, output bit busy1);
    @(negedge clk);
    wdata = d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    busy1 = busy;
    ccyc = 0; dcyc = 0; dlast = 1'b0;
    while (ps2_clk_oe === 1'b1 && ccyc < 4 * INH) begin
      ccyc++;
      if (ps2_data_oe === 1'b1) dcyc++;
      dlast = ps2_data_oe;
      @(negedge clk);
    end
  endtask

  // Device side: nfalls clock pulses, sampling the data line just before each rise.
  task automatic dev_frame(input bit ack, input int nfalls, output logic [9:0] bits);
    bits = '0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      if (i == 10 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (i < 10) bits[i] = data_line;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    send = 1'b1;
    wdata = 8'hED;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ps2_clk_oe, ps2_data_oe, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, ps2_clk_oe, ps2_data_oe, done, err});
    end
    clr = 1'b0;
    send = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_send_ignored: busy=%b clk_oe=%b want 0 0", busy, ps2_clk_oe);
    end
  endtask

  task automatic test_send_ed;
    int c, dc, cyc, d0, e0;
    bit dl, b1;
    logic [9:0] bits;
    d0 = done_n; e0 = err_n;
    do_send(8'hED, c, dc, dl, b1);
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL ed_busy_next: got %b want 1", b1); end
    checks++;
    if (c != INH) begin errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", c, INH); end
    checks++;
    if (dc != 1 || dl !== 1'b1) begin
      errors++; $display("FAIL ed_inhibit_data: count=%0d last=%b want 1 1", dc, dl);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
      errors++; $display("FAIL ed_start_bit: clk_oe=%b data_oe=%b want 0 1", ps2_clk_oe, ps2_data_oe);
    end
    dev_frame(1'b1, 11, bits);
    checks++;
    if (bits !== 10'b11_1110_1101) begin
      errors++; $display("FAIL ed_frame: got %b want 1111101101", bits);
    end
    wait_idle(cyc);
    checks++;
    if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL ed_idle: busy=%b clk_oe=%b data_oe=%b want 000", busy, ps2_clk_oe, ps2_data_oe);
    end
    checks++;
    if (done_n - d0 != 1 || err_n - e0 != 0) begin
      errors++; $display("FAIL ed_pulses: done=%0d err=%0d want 1 0", done_n - d0, err_n - e0);
    end
  endtask

  task automatic test_parity;
    logic [7:0] dv [3] = '{8'h00, 8'h01, 8'hFF};
    logic       pv [3] = '{1'b1, 1'b0, 1'b1};
    int c, dc, cyc, d0;
    bit dl, b1;
    logic [9:0] bits;
    for (int k = 0; k < 3; k++) begin
      d0 = done_n;
      do_send(dv[k], c, dc, dl, b1);
      dev_frame(1'b1, 11, bits);
      wait_idle(cyc);
      checks++;
      if (bits !== {1'b1, pv[k], dv[k]}) begin
        errors++; $display("FAIL parity_frame_%02h: got %b want %b", dv[k], bits, {1'b1, pv[k], dv[k]});
      end
      checks++;
      if (done_n - d0 != 1 || busy !== 1'b0) begin
        errors++; $display("FAIL parity_done_%02h: done=%0d busy=%b want 1 0", dv[k], done_n - d0, busy);
      end
    end
  endtask

  task automatic test_no_ack;
    int c, dc, cyc, d0, e0;
    bit dl, b1;
    logic [9:0] bits;
    d0 = done_n; e0 = err_n;
    do_send(8'h3C, c, dc, dl, b1);
    dev_frame(1'b0, 11, bits);
    wait_idle(cyc);
    checks++;
    if (bits !== 10'b11_0011_1100) begin
      errors++; $display("FAIL noack_frame: got %b want 1100111100", bits);
    end
    checks++;
    if (err_n - e0 != 1 || done_n - d0 != 0) begin
      errors++; $display("FAIL noack_pulses: err=%0d done=%0d want 1 0", err_n - e0, done_n - d0);
    end
    checks++;
    if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL noack_release: busy=%b clk_oe=%b data_oe=%b want 000", busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_clr_mid;
    int c, dc, cyc, d0;
    bit dl, b1;
    logic [9:0] bits;
    do_send(8'hA5, c, dc, dl, b1);
    dev_frame(1'b1, 5, bits);
    checks++;
    if (bits[4:0] !== 5'b00101 || ps2_data_oe !== 1'b1) begin
      errors++; $display("FAIL clr_pre: bits=%b data_oe=%b want 00101 1", bits[4:0], ps2_data_oe);
    end
    #3 clr = 1'b1;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_async: clk_oe=%b data_oe=%b busy=%b want 000", ps2_clk_oe, ps2_data_oe, busy);
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    d0 = done_n;
    do_send(8'hF4, c, dc, dl, b1);
    dev_frame(1'b1, 11, bits);
    wait_idle(cyc);
    checks++;
    if (bits !== 10'b10_1111_0100 || done_n - d0 != 1) begin
      errors++; $display("FAIL clr_resend: frame=%b done=%0d want 1011110100 1", bits, done_n - d0);
    end
  endtask

  task automatic test_back_to_back;
    int t, cyc, d0, bz;
    logic [9:0] bits;
    d0 = done_n;
    @(negedge clk);
    wdata = 8'h12; send = 1'b1;
    @(negedge clk);
    wdata = 8'h55; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    t = 0;
    while (ps2_clk_oe === 1'b1 && t < 4 * INH) begin @(negedge clk); t++; end
    dev_frame(1'b1, 11, bits);
    wait_idle(cyc);
    checks++;
    if (bits !== 10'b11_0001_0010) begin
      errors++; $display("FAIL b2b_frame: got %b want 1100010010", bits);
    end
    checks++;
    if (done_n - d0 != 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", done_n - d0); end
    bz = 0;
    repeat (60) begin @(negedge clk); if (busy === 1'b1) bz++; end
    checks++;
    if (bz != 0) begin errors++; $display("FAIL b2b_no_second: busy cycles=%0d want 0", bz); end
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout;
    int c, dc, cyc, d0, e0, n;
    bit dl, b1;
    logic [9:0] bits;
    d0 = done_n; e0 = err_n;
    do_send(8'hED, c, dc, dl, b1);
    dev_frame(1'b1, 3, bits);
    dev_clk = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == H) dev_clk = 1'b1;
    end while (err !== 1'b1 && n < 2 * TMO);
    // two synchronizer cycles between the line fall and its detection
    checks++;
    if (n != TMO + 2) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", n, TMO + 2); end
    wait_idle(cyc);
    checks++;
    if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL timeout_release: busy=%b clk_oe=%b data_oe=%b want 000", busy, ps2_clk_oe, ps2_data_oe);
    end
    checks++;
    if (err_n - e0 != 1 || done_n - d0 != 0) begin
      errors++; $display("FAIL timeout_pulses: err=%0d done=%0d want 1 0", err_n - e0, done_n - d0);
    end
  endtask
`else
  task automatic test_no_watchdog;
    int c, dc, e0;
    bit dl, b1;
    logic [9:0] bits;
    e0 = err_n;
    do_send(8'hED, c, dc, dl, b1);
    dev_frame(1'b1, 4, bits);
    repeat (2 * TMO) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err_n - e0 != 0) begin
      errors++; $display("FAIL nowd_waits: busy=%b err=%0d want 1 0", busy, err_n - e0);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nowd_clr: busy=%b want 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_no_ack();
    test_clr_mid();
    test_back_to_back();
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`else
    test_no_watchdog();
`endif
    checks++;
    if (both_n != 0) begin errors++; $display("FAIL done_err_overlap: got %0d want 0", both_n); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
